watermark_verifier: RTL and testbench
=====================================

Name: watermark_verifier

Overview:
- Sits directly downstream of the watermark extractor and consumes its extracted-watermark pixel stream.
- Each extracted pixel arrives paired with the matching pixel of the original watermark.
- Accumulates two figures over one full watermark frame: a binarised bit-error count and a sum of absolute differences (SAD).
- Issues a pass/fail verdict against a programmable error budget. Pure streaming; no frame memory.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- WATERMARK_WIDTH, 128, watermark columns.
- WATERMARK_HEIGHT, 128, watermark rows.
- BIN_THRESHOLD, 128, a pixel binarises to 1 when its value is >= this.
- MAX_BIT_ERRORS, 1638, pass when bit_errors <= this (about 10% of 16384).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a frame; honoured only in S_IDLE or S_DONE.
- in_valid  in  1  pixel pair valid.
- in_ready  out  1  block accepts a pair; high only in S_ACCUM.
- ext_pixel  in  PIXEL_WIDTH  extracted watermark pixel.
- ref_pixel  in  PIXEL_WIDTH  original watermark pixel.
- busy  out  1  high in S_ACCUM and S_FINAL.
- done  out  1  level; results valid while high.
- bit_errors  out  CNT_W  count of binarised mismatches; CNT_W = clog2(WM_SIZE+1).
- sad  out  SAD_W  sum of absolute differences; SAD_W = PIXEL_WIDTH + clog2(WM_SIZE).
- pass  out  1  1 when bit_errors <= MAX_BIT_ERRORS; valid only with done.
- worst_row  out  clog2(WATERMARK_HEIGHT)  optional feature; otherwise 0.
- worst_row_errors  out  clog2(WATERMARK_WIDTH+1)  optional feature; otherwise 0.

Behaviour:
- Reset (asynchronous, any state including mid-frame):
  - state S_IDLE; all counters, accumulators and pipeline valids cleared.
  - Outputs: in_ready=0, busy=0, done=0, bit_errors=0, sad=0, pass=0, worst_row/worst_row_errors=0.
- WM_SIZE = WATERMARK_WIDTH*WATERMARK_HEIGHT.
- FSM states: S_IDLE, S_ACCUM, S_FINAL, S_DONE.
  - S_IDLE/S_DONE -> S_ACCUM on start.
    - Clears accumulators, beat counter and done in the same edge.
    - Results are held in S_DONE until the next start.
  - S_ACCUM: in_ready=1. A beat is accepted on in_valid && in_ready. Beat counter increments per beat.
    - On the beat where the counter reaches WM_SIZE-1: -> S_FINAL, and in_ready=0 from the next cycle.
  - S_FINAL: drains the pipeline, no acceptance, fixed 2 cycles, then -> S_DONE with done=1.
  - start while busy is ignored.
- Pipeline:
  - Stage 1 (cycle after accept) registers:
    - mismatch = (ext_pixel>=BIN_THRESHOLD) ^ (ref_pixel>=BIN_THRESHOLD).
    - absdiff = |ext_pixel - ref_pixel|, unsigned, PIXEL_WIDTH bits.
  - Stage 2 adds both to bit_errors and sad.
- Latency: with the last beat accepted at edge N, done=1 and final results are visible after edge N+3. pass is computed combinationally from final bit_errors and registered with done.
- Width rule: accumulators sized so the maximum (all mismatches, all absdiff=255) cannot overflow. No saturation logic.
- in_valid low in S_ACCUM stalls: no count change, pipeline bubbles are harmless (valid-qualified).
- bit_errors and sad update live during S_ACCUM. Consumers sample them only while done=1.

Optional Feature:
- Macro WM_VERIFY_WORST_ROW_EN.
- Defined:
  - A per-row mismatch counter resets at each row boundary (every WATERMARK_WIDTH beats).
  - At the row end it is compared against the running maximum. A strictly greater count updates worst_row_errors and worst_row; ties keep the earlier row.
  - Final values are valid with done.
- Undefined: the logic is absent and both outputs are tied to 0.

Decomposition:
- Package wm_verify_pkg holds:
  - state encoding constants;
  - clog2 function;
  - derived widths CNT_W and SAD_W.
- One natural sub-module: wm_pixel_compare, the stage-1 registered binarise/XOR and absolute-difference unit, reusable by the embedder-side checker.
- FSM, counters and accumulators stay in the top module.

Test Plan:
- Identical streams (ext=ref=ramp 0..255 repeated), in_valid always high -> done 3 cycles after the last beat; bit_errors=0, sad=0, pass=1.
- ext=255, ref=0 for all 16384 beats -> bit_errors=16384, sad=4177920 (no overflow), pass=0.
- Exactly 1638 mismatches (ext=200, ref=50 on the first 1638 beats, equal otherwise) -> pass=1. Repeat with 1639 mismatches -> pass=0; sad=1638*150 and 1639*150 respectively.
- Random in_valid gaps of 0-5 cycles and a start pulse while busy -> results identical to the gap-free run; start ignored; in_ready low after the final beat.
- rst_n asserted at beat 8000, then a fresh start with a clean frame -> all outputs 0 during reset; second frame gives bit_errors=0, pass=1.
- WM_VERIFY_WORST_ROW_EN defined: row 5 has 10 mismatches, row 90 has 10, row 40 has 7 -> worst_row=5, worst_row_errors=10.

Source files
------------

// File: rtl/wm_verify_pkg.sv
// -----------------------------------------------------------------------------
// wm_verify_pkg
// Shared definitions for the watermark verifier slice:
//   - state_t       : verifier FSM state encoding
//   - clog2         : ceiling log2 usable in constant expressions
//   - cnt_width     : bits needed to hold a count 0..n inclusive
//   - idx_width     : bits needed to index 0..n-1 (never less than 1)
//   - sad_width     : SAD accumulator width for a pixel width and frame size
//   - CNT_W / SAD_W : derived widths for the default 8-bit 128x128 watermark
// -----------------------------------------------------------------------------
package wm_verify_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int cnt_width(input int n);
    return clog2(n + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Every pixel can contribute at most 2^pw - 1, so pw + clog2(size) bits
  // hold the worst case without wrapping.
  function automatic int sad_width(input int pw, input int size);
    return pw + clog2(size);
  endfunction

  localparam int DEF_PIXEL_WIDTH = 8;
  localparam int DEF_WM_SIZE     = 128 * 128;
  localparam int CNT_W           = cnt_width(DEF_WM_SIZE);
  localparam int SAD_W           = sad_width(DEF_PIXEL_WIDTH, DEF_WM_SIZE);

endpackage

// File: rtl/wm_pixel_compare.sv
// -----------------------------------------------------------------------------
// wm_pixel_compare
// Stage-1 registered pixel comparator: binarises both pixels against
// BIN_THRESHOLD, flags a disagreement, and computes |ext - ref|.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_valid               pair present this cycle (already handshaken)
//   i_ext_pixel           extracted pixel
//   i_ref_pixel           reference pixel
//   o_valid               registered copy of i_valid
//   o_mismatch            registered binarised mismatch
//   o_absdiff             registered absolute difference
// -----------------------------------------------------------------------------
module wm_pixel_compare
  import wm_verify_pkg::*;
#(
  parameter int PIXEL_WIDTH   = DEF_PIXEL_WIDTH,
  parameter int BIN_THRESHOLD = 128
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  input  logic [PIXEL_WIDTH-1:0] i_ext_pixel,
  input  logic [PIXEL_WIDTH-1:0] i_ref_pixel,
  output logic                   o_valid,
  output logic                   o_mismatch,
  output logic [PIXEL_WIDTH-1:0] o_absdiff
);

  localparam logic [PIXEL_WIDTH-1:0] THR = PIXEL_WIDTH'(BIN_THRESHOLD);

  logic                   w_mismatch;
  logic [PIXEL_WIDTH-1:0] w_absdiff;

  assign w_mismatch = (i_ext_pixel >= THR) ^ (i_ref_pixel >= THR);
  assign w_absdiff  = (i_ext_pixel >= i_ref_pixel) ? (i_ext_pixel - i_ref_pixel)
                                                   : (i_ref_pixel - i_ext_pixel);

  logic                   r_valid;
  logic                   r_mismatch;
  logic [PIXEL_WIDTH-1:0] r_absdiff;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
      r_absdiff  <= '0;
    end else begin
      r_valid    <= i_valid;
      r_mismatch <= w_mismatch;
      r_absdiff  <= w_absdiff;
    end
  end

  assign o_valid    = r_valid;
  assign o_mismatch = r_mismatch;
  assign o_absdiff  = r_absdiff;

endmodule

// File: rtl/watermark_verifier.sv
// -----------------------------------------------------------------------------
// watermark_verifier
// Streams one watermark frame of (extracted, reference) pixel pairs and
// produces a binarised bit-error count, a sum of absolute differences and a
// pass/fail verdict against MAX_BIT_ERRORS. No frame storage.
//
// Handshake: a pair is transferred on a rising edge where i_in_valid and
// o_in_ready are both high. o_in_ready depends only on FSM state (high in
// S_ACCUM), never on i_in_valid; the source may hold or drop i_in_valid freely.
//
// Optional feature (macro WM_VERIFY_WORST_ROW_EN): tracks the row with the
// most mismatches (earliest row wins ties). Without the macro, o_worst_row
// and o_worst_row_errors are tied to 0.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_start                begin a frame (honoured in S_IDLE / S_DONE only)
//   i_in_valid/o_in_ready  pair handshake
//   i_ext_pixel/i_ref_pixel pixel pair
//   o_busy                 high in S_ACCUM and S_FINAL
//   o_done                 results valid while high (held until next start)
//   o_bit_errors, o_sad    accumulators (live during S_ACCUM)
//   o_pass                 verdict, valid with o_done
//   o_worst_row, o_worst_row_errors  optional worst-row report
//   o_state                current FSM state (debug)
// -----------------------------------------------------------------------------
module watermark_verifier
  import wm_verify_pkg::*;
#(
  parameter int  PIXEL_WIDTH      = 8,
  parameter int  WATERMARK_WIDTH  = 128,
  parameter int  WATERMARK_HEIGHT = 128,
  parameter int  BIN_THRESHOLD    = 128,
  parameter int  MAX_BIT_ERRORS   = 1638,
  localparam int WM_SIZE  = WATERMARK_WIDTH * WATERMARK_HEIGHT,
  localparam int ERR_W    = cnt_width(WM_SIZE),
  localparam int ACC_W    = sad_width(PIXEL_WIDTH, WM_SIZE),
  localparam int ROW_W    = idx_width(WATERMARK_HEIGHT),
  localparam int ROWERR_W = cnt_width(WATERMARK_WIDTH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic [PIXEL_WIDTH-1:0] i_ext_pixel,
  input  logic [PIXEL_WIDTH-1:0] i_ref_pixel,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [ERR_W-1:0]       o_bit_errors,
  output logic [ACC_W-1:0]       o_sad,
  output logic                   o_pass,
  output logic [ROW_W-1:0]       o_worst_row,
  output logic [ROWERR_W-1:0]    o_worst_row_errors,
  output logic [1:0]             o_state
);

  localparam int BEAT_W = idx_width(WM_SIZE);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BEAT_W-1:0]  r_beat;
  logic [1:0]         r_fin_cnt;
  logic [ERR_W-1:0]   r_bit_errors;
  logic [ACC_W-1:0]   r_sad;
  logic               r_done;
  logic               r_pass;

  logic               w_in_ready;
  logic               w_busy;
  logic               w_accept;
  logic               w_last_beat;
  logic               w_start_ok;
  logic               w_fin_end;
  logic               w_pass_nxt;

  logic                   w_s1_valid;
  logic                   w_s1_mismatch;
  logic [PIXEL_WIDTH-1:0] w_s1_absdiff;

  assign w_accept    = w_in_ready && i_in_valid;
  assign w_last_beat = w_accept && (r_beat == BEAT_W'(WM_SIZE - 1));
  assign w_start_ok  = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // S_FINAL spans the stage-1 and stage-2 drain edges plus the edge that
  // registers the verdict, so done rises three edges after the last beat.
  assign w_fin_end   = (r_state == S_FINAL) && (r_fin_cnt == 2'd2);
  assign w_pass_nxt  = (int'(r_bit_errors) <= MAX_BIT_ERRORS);

  // ---------------- FSM ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_start) w_state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_last_beat) w_state_nxt = S_FINAL;
      end
      S_FINAL: begin
        w_busy = 1'b1;
        if (w_fin_end) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------- stage 1 ----------------
  wm_pixel_compare #(
    .PIXEL_WIDTH  (PIXEL_WIDTH),
    .BIN_THRESHOLD(BIN_THRESHOLD)
  ) u_compare (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (w_accept),
    .i_ext_pixel(i_ext_pixel),
    .i_ref_pixel(i_ref_pixel),
    .o_valid    (w_s1_valid),
    .o_mismatch (w_s1_mismatch),
    .o_absdiff  (w_s1_absdiff)
  );

  // ---------------- counters, stage 2, verdict ----------------
  // start is only honoured while the pipeline is empty, so clearing the
  // accumulators never collides with a stage-2 add.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_beat       <= '0;
      r_fin_cnt    <= 2'd0;
      r_bit_errors <= '0;
      r_sad        <= '0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      if (w_start_ok)    r_beat <= '0;
      else if (w_accept) r_beat <= r_beat + 1'b1;

      if (r_state == S_FINAL) r_fin_cnt <= r_fin_cnt + 2'd1;
      else                    r_fin_cnt <= 2'd0;

      if (w_start_ok) begin
        r_bit_errors <= '0;
        r_sad        <= '0;
      end else if (w_s1_valid) begin
        r_bit_errors <= r_bit_errors + ERR_W'(w_s1_mismatch);
        r_sad        <= r_sad + ACC_W'(w_s1_absdiff);
      end

      if (w_start_ok) begin
        r_done <= 1'b0;
        r_pass <= 1'b0;
      end else if (w_fin_end) begin
        r_done <= 1'b1;
        r_pass <= w_pass_nxt;
      end
    end
  end

  // ---------------- optional worst-row tracking ----------------
`ifdef WM_VERIFY_WORST_ROW_EN
  localparam int COL_W = idx_width(WATERMARK_WIDTH);

  logic [COL_W-1:0]    r_col;
  logic [ROW_W-1:0]    r_row;
  logic [ROWERR_W-1:0] r_row_err;
  logic [ROWERR_W-1:0] r_worst_err;
  logic [ROW_W-1:0]    r_worst_row;
  logic [ROWERR_W-1:0] w_row_err_nxt;

  // Row position follows stage-2 beats, so it stays aligned with the
  // mismatch bit it is counting even across input stalls.
  assign w_row_err_nxt = r_row_err + ROWERR_W'(w_s1_mismatch);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_row_err   <= '0;
      r_worst_err <= '0;
      r_worst_row <= '0;
    end else if (w_start_ok) begin
      r_col       <= '0;
      r_row       <= '0;
      r_row_err   <= '0;
      r_worst_err <= '0;
      r_worst_row <= '0;
    end else if (w_s1_valid) begin
      if (r_col == COL_W'(WATERMARK_WIDTH - 1)) begin
        r_col     <= '0;
        r_row_err <= '0;
        r_row     <= r_row + 1'b1;
        // Strictly greater: an equal later row does not displace the earlier.
        if (w_row_err_nxt > r_worst_err) begin
          r_worst_err <= w_row_err_nxt;
          r_worst_row <= r_row;
        end
      end else begin
        r_col     <= r_col + 1'b1;
        r_row_err <= w_row_err_nxt;
      end
    end
  end

  assign o_worst_row        = r_worst_row;
  assign o_worst_row_errors = r_worst_err;
`else
  assign o_worst_row        = '0;
  assign o_worst_row_errors = '0;
`endif

  assign o_in_ready   = w_in_ready;
  assign o_busy       = w_busy;
  assign o_done       = r_done;
  assign o_pass       = r_pass;
  assign o_bit_errors = r_bit_errors;
  assign o_sad        = r_sad;
  assign o_state      = r_state;

endmodule

// File: tb/tb_watermark_verifier.sv
// -----------------------------------------------------------------------------
// tb_watermark_verifier
// Frame-level bench for watermark_verifier (default 8-bit 128x128 build).
// Honours WM_VERIFY_WORST_ROW_EN to add the worst-row frame and expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_watermark_verifier;
  import wm_verify_pkg::*;

  localparam int WM_W = 128;
  localparam int WM_H = 128;
  localparam int WM   = WM_W * WM_H;
  localparam int THR  = 128;

`ifdef WM_VERIFY_WORST_ROW_EN
  localparam bit WR_EN = 1'b1;
`else
  localparam bit WR_EN = 1'b0;
`endif

  localparam int K_ALLMIS = 0;
  localparam int K_NMIS   = 1;
  localparam int K_RAMP   = 2;
  localparam int K_ROWS   = 3;
  localparam int K_RAND   = 4;

  // ---------------- clock / reset signals ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ext_pix;
  logic [7:0]  ref_pix;
  logic        busy;
  logic        done;
  logic [14:0] bit_errors;
  logic [21:0] sad;
  logic        pass;
  logic [6:0]  worst_row;
  logic [7:0]  worst_row_errors;
  logic [1:0]  state;

  always #5 clk = ~clk;

  watermark_verifier dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_start           (start),
    .i_in_valid        (in_valid),
    .o_in_ready        (in_ready),
    .i_ext_pixel       (ext_pix),
    .i_ref_pixel       (ref_pix),
    .o_busy            (busy),
    .o_done            (done),
    .o_bit_errors      (bit_errors),
    .o_sad             (sad),
    .o_pass            (pass),
    .o_worst_row       (worst_row),
    .o_worst_row_errors(worst_row_errors),
    .o_state           (state)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          ext_a[WM];
  int          ref_a[WM];

  typedef struct {
    string name;
    int    kind;
    int    nmis;
    bit    gaps;
    bit    poke;
    int    exp_be;
    int    exp_sad;
    bit    exp_pass;
    int    exp_wr;
    int    exp_wre;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, expv);
    end
  endtask

  task automatic sb_check(input string name, input logic [31:0] act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: actual %0d required <nothing queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      check(name, act, e);
    end
  endtask

  task automatic check_reset(input string name);
    check({name, ".in_ready"}, 32'(in_ready), 0);
    check({name, ".busy"}, 32'(busy), 0);
    check({name, ".done"}, 32'(done), 0);
    check({name, ".bit_errors"}, 32'(bit_errors), 0);
    check({name, ".sad"}, 32'(sad), 0);
    check({name, ".pass"}, 32'(pass), 0);
    check({name, ".worst_row"}, 32'(worst_row), 0);
    check({name, ".worst_row_errors"}, 32'(worst_row_errors), 0);
    check({name, ".state"}, 32'(state), 32'(S_IDLE));
  endtask

  // ---------------- reference model ----------------
  // Straight from the definitions: count binarised disagreements and sum
  // |e - r| over the first n pairs; worst row is the first row holding the
  // largest mismatch count (a row of zero never qualifies).
  task automatic model(input int n, output int be, output int sd, output int wr, output int wre);
    int row_err[WM_H];
    be = 0;
    sd = 0;
    for (int r = 0; r < WM_H; r++) row_err[r] = 0;
    for (int i = 0; i < n; i++) begin
      if ((ext_a[i] >= THR) != (ref_a[i] >= THR)) begin
        be++;
        row_err[i / WM_W]++;
      end
      sd += (ext_a[i] > ref_a[i]) ? (ext_a[i] - ref_a[i]) : (ref_a[i] - ext_a[i]);
    end
    wr  = 0;
    wre = 0;
    for (int r = 0; r < WM_H; r++) begin
      if (row_err[r] > wre) begin
        wre = row_err[r];
        wr  = r;
      end
    end
  endtask

  task automatic fill_frame(input int kind, input int nmis);
    int v;
    for (int i = 0; i < WM; i++) begin
      v = int'($urandom_range(0, 255));
      case (kind)
        K_ALLMIS: begin ext_a[i] = 255; ref_a[i] = 0; end
        K_NMIS: begin
          if (i < nmis) begin ext_a[i] = 200; ref_a[i] = 50; end
          else          begin ext_a[i] = v;   ref_a[i] = v;  end
        end
        K_RAMP:  begin ext_a[i] = i % 256; ref_a[i] = i % 256; end
        K_RAND:  begin ext_a[i] = v; ref_a[i] = int'($urandom_range(0, 255)); end
        default: begin ext_a[i] = v; ref_a[i] = v; end
      endcase
    end
    if (kind == K_ROWS) begin
      for (int c = 0;   c < 10;  c++) begin ext_a[5*WM_W+c]  = 200; ref_a[5*WM_W+c]  = 50;  end
      for (int c = 3;   c < 13;  c++) begin ext_a[90*WM_W+c] = 10;  ref_a[90*WM_W+c] = 240; end
      for (int c = 100; c < 107; c++) begin ext_a[40*WM_W+c] = 130; ref_a[40*WM_W+c] = 127; end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_start(input string name);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ".start.in_ready"}, 32'(in_ready), 1);
    check({name, ".start.done_cleared"}, 32'(done), 0);
    check({name, ".start.bit_errors_cleared"}, 32'(bit_errors), 0);
    check({name, ".start.sad_cleared"}, 32'(sad), 0);
  endtask

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic drive_frame(input string name, input int nbeats, input bit gaps, input bit poke);
    int i     = 0;
    int gap   = 0;
    int guard = 0;
    while (i < nbeats && guard < nbeats * 8 + 1000) begin
      start = poke && (i == 5000);
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else begin
        in_valid = 1'b1;
        ext_pix  = 8'(ext_a[i]);
        ref_pix  = 8'(ref_a[i]);
        if (in_ready) begin
          i++;
          if (gaps && $urandom_range(0, 31) == 0) gap = int'($urandom_range(0, 5));
        end
      end
      guard++;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (i < nbeats) check({name, ".beats_accepted"}, 32'(i), 32'(nbeats));
  endtask

  task automatic finish_frame(input string name);
    int lat = 0;
    check({name, ".in_ready_after_last"}, 32'(in_ready), 0);
    check({name, ".busy_after_last"}, 32'(busy), 1);
    while (done !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, ".done_latency"}, 32'(lat), 3);
    sb_check({name, ".bit_errors"}, 32'(bit_errors));
    sb_check({name, ".sad"}, 32'(sad));
    sb_check({name, ".pass"}, 32'(pass));
    sb_check({name, ".worst_row"}, 32'(worst_row));
    sb_check({name, ".worst_row_errors"}, 32'(worst_row_errors));
    check({name, ".busy_at_done"}, 32'(busy), 0);
  endtask

  task automatic push_exp(input int be, input int sd, input bit ps, input int wr, input int wre);
    exp_q.push_back(32'(be));
    exp_q.push_back(32'(sd));
    exp_q.push_back(32'(ps));
    exp_q.push_back(WR_EN ? 32'(wr) : 32'd0);
    exp_q.push_back(WR_EN ? 32'(wre) : 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int be, sd, wr, wre;
    int last_sad;

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    ext_pix  = '0;
    ref_pix  = '0;

    tbl.push_back('{"all_mismatch",  K_ALLMIS, 0,    1'b0, 1'b0, 16384, 4177920, 1'b0, 0, 128});
    tbl.push_back('{"mis_1638_gaps", K_NMIS,   1638, 1'b1, 1'b1, 1638,  245700,  1'b1, 0, 128});
    tbl.push_back('{"mis_1639",      K_NMIS,   1639, 1'b0, 1'b0, 1639,  245850,  1'b0, 0, 128});
`ifdef WM_VERIFY_WORST_ROW_EN
    tbl.push_back('{"worst_rows",    K_ROWS,   0,    1'b0, 1'b0, 27,    3821,    1'b1, 5, 10});
`endif

    repeat (3) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle.in_ready", 32'(in_ready), 0);

    last_sad = 0;
    foreach (tbl[k]) begin
      fill_frame(tbl[k].kind, tbl[k].nmis);
      push_exp(tbl[k].exp_be, tbl[k].exp_sad, tbl[k].exp_pass, tbl[k].exp_wr, tbl[k].exp_wre);
      do_start(tbl[k].name);
      drive_frame(tbl[k].name, WM, tbl[k].gaps, tbl[k].poke);
      finish_frame(tbl[k].name);
      last_sad = tbl[k].exp_sad;
    end

    // Results must hold in S_DONE with no start.
    repeat (5) @(negedge clk);
    check("hold.done", 32'(done), 1);
    check("hold.sad", 32'(sad), 32'(last_sad));

    // Random frame aborted by reset at beat 8000; live totals checked first.
    fill_frame(K_RAND, 0);
    model(8000, be, sd, wr, wre);
    do_start("abort");
    drive_frame("abort", 8000, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("abort.live_bit_errors", 32'(bit_errors), 32'(be));
    check("abort.live_sad", 32'(sad), 32'(sd));
    // Put one beat in flight so the reset lands on a non-empty pipeline.
    ext_pix  = 8'd255;
    ref_pix  = 8'd0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_reset("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh clean frame after the reset.
    fill_frame(K_RAMP, 0);
    model(WM, be, sd, wr, wre);
    push_exp(be, sd, 1'b1, wr, wre);
    do_start("clean_ramp");
    drive_frame("clean_ramp", WM, 1'b0, 1'b0);
    finish_frame("clean_ramp");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
